// File: rtl/cpu_sequencer.sv
// Cycle sequencer for the 2A03 core: tracks the T-state, latches the opcode on
// the fetch cycle, polls reset/NMI/IRQ and injects a forced BRK with its kind.
module cpu_sequencer #(
   parameter logic [7:0]  RESET_OPCODE = 8'h00,
   parameter int unsigned MAX_CYC      = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        rdy,
   input  logic        instr_done,
   input  logic        irq_mask,
   input  logic        nnmi,
   input  logic        nirq,
   output logic [7:0]  instr,
   output logic [2:0]  cyc_count,
   output logic        opcode_fetch,
   output logic        pc_inc,
   output logic [1:0]  int_kind,
   output logic [15:0] vector,
   output logic        jam
);

   localparam int unsigned CYC_W = 3;
   localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(MAX_CYC);

   typedef enum logic [1:0] {
      KIND_NONE  = 2'b00,
      KIND_RESET = 2'b01,
      KIND_NMI   = 2'b10,
      KIND_IRQ   = 2'b11
   } kind_e;

   logic [7:0]       instr_q, instr_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   kind_e            kind_q, kind_d;
   kind_e            kind_next_q, kind_next_d;
   logic             jam_q, jam_d;
   logic             take_q, take_d;
   logic             pend_q, pend_d;
   logic             nmi_prev_q;
   logic             nmi_edge;

   // Next-state: NMI edge capture every cycle, everything else gated by rdy
   always_comb begin
      instr_d     = instr_q;
      cyc_d       = cyc_q;
      kind_d      = kind_q;
      kind_next_d = kind_next_q;
      jam_d       = jam_q;
      take_d      = take_q;
      nmi_edge    = nmi_prev_q & ~nnmi;
      pend_d      = pend_q | nmi_edge;
      if (rdy) begin
         if (cyc_q == '0) begin
            // fetch cycle: latch memory opcode or inject the forced BRK
            cyc_d = CYC_W'(1);
            if (take_q) begin
               instr_d = RESET_OPCODE;
               kind_d  = kind_next_q;
               take_d  = 1'b0;
               // a fresh edge arriving on the same cycle stays pending
               if (kind_next_q == KIND_NMI && !nmi_edge) begin
                  pend_d = 1'b0;
               end
            end else begin
               instr_d = data_in;
               kind_d  = KIND_NONE;
            end
         end else if (!jam_q) begin
            if (instr_done) begin
               cyc_d       = '0;
               take_d      = pend_q | (~nirq & ~irq_mask);
               kind_next_d = pend_q ? KIND_NMI : KIND_IRQ;
            end else if (cyc_q < CYC_MAX) begin
               cyc_d = cyc_q + CYC_W'(1);
            end else begin
               jam_d = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset into the reset BRK sequence at T1
   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q     <= RESET_OPCODE;
         cyc_q       <= CYC_W'(1);
         kind_q      <= KIND_RESET;
         kind_next_q <= KIND_NONE;
         jam_q       <= 1'b0;
         take_q      <= 1'b0;
         pend_q      <= 1'b0;
         nmi_prev_q  <= 1'b1;
      end else begin
         instr_q     <= instr_d;
         cyc_q       <= cyc_d;
         kind_q      <= kind_d;
         kind_next_q <= kind_next_d;
         jam_q       <= jam_d;
         take_q      <= take_d;
         pend_q      <= pend_d;
         nmi_prev_q  <= nnmi;
      end
   end

   // Vector decode from the active interrupt kind
   always_comb begin
      vector = 16'hFFFE;
      case (kind_q)
         KIND_RESET: vector = 16'hFFFC;
         KIND_NMI:   vector = 16'hFFFA;
         default:    vector = 16'hFFFE;
      endcase
   end

   assign instr        = instr_q;
   assign cyc_count    = cyc_q;
   assign int_kind     = kind_q;
   assign jam          = jam_q;
   assign opcode_fetch = (cyc_q == '0);
   assign pc_inc       = opcode_fetch & ~take_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed test-plan steps followed by
// randomized traffic, all compared against an instruction-level reference model.
module tb_cpu_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  data_in;
   logic        rdy;
   logic        instr_done;
   logic        irq_mask;
   logic        nnmi;
   logic        nirq;
   logic [7:0]  instr;
   logic [2:0]  cyc_count;
   logic        opcode_fetch;
   logic        pc_inc;
   logic [1:0]  int_kind;
   logic [15:0] vector;
   logic        jam;

   int n_vec = 0;
   int n_err = 0;

   cpu_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .data_in      (data_in),
      .rdy          (rdy),
      .instr_done   (instr_done),
      .irq_mask     (irq_mask),
      .nnmi         (nnmi),
      .nirq         (nirq),
      .instr        (instr),
      .cyc_count    (cyc_count),
      .opcode_fetch (opcode_fetch),
      .pc_inc       (pc_inc),
      .int_kind     (int_kind),
      .vector       (vector),
      .jam          (jam)
   );

   always #5 clock = ~clock;

   // Reference state in the sequencer's architectural terms
   typedef struct {
      logic [7:0]  opcode;
      int unsigned tstate;
      int unsigned kind;      // 0 none, 1 reset, 2 NMI, 3 IRQ
      bit          jammed;
      bit          nmi_waiting;
      bit          int_due;
      int unsigned due_kind;
      bit          pin_was_high;
   } model_t;

   model_t m;

   function automatic model_t model_step(input model_t s);
      model_t n = s;
      bit fell;
      if (reset) begin
         n.opcode = 8'h00; n.tstate = 1; n.kind = 1; n.jammed = 0;
         n.nmi_waiting = 0; n.int_due = 0; n.due_kind = 0; n.pin_was_high = 1;
         return n;
      end
      fell = s.pin_was_high && !nnmi;
      n.pin_was_high = nnmi;
      if (fell) n.nmi_waiting = 1;
      if (!rdy) return n;
      if (s.tstate == 0) begin
         n.tstate = 1;
         if (s.int_due) begin
            n.opcode  = 8'h00;
            n.kind    = s.due_kind;
            n.int_due = 0;
            if (s.due_kind == 2 && !fell) n.nmi_waiting = 0;
         end else begin
            n.opcode = data_in;
            n.kind   = 0;
         end
      end else if (!s.jammed) begin
         if (instr_done) begin
            n.tstate   = 0;
            n.int_due  = s.nmi_waiting || (!nirq && !irq_mask);
            n.due_kind = s.nmi_waiting ? 2 : 3;
         end else if (s.tstate < 7) begin
            n.tstate = s.tstate + 1;
         end else begin
            n.jammed = 1;
         end
      end
      return n;
   endfunction

   function automatic logic [15:0] vec_of(input int unsigned k);
      if (k == 1) return 16'hFFFC;
      if (k == 2) return 16'hFFFA;
      return 16'hFFFE;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("instr",        16'(instr),        16'(m.opcode));
      chk("cyc_count",    16'(cyc_count),    16'(m.tstate));
      chk("int_kind",     16'(int_kind),     16'(m.kind));
      chk("jam",          16'(jam),          16'(m.jammed));
      chk("opcode_fetch", 16'(opcode_fetch), 16'(m.tstate == 0));
      chk("pc_inc",       16'(pc_inc),       16'(m.tstate == 0 && !m.int_due));
      chk("vector",       vector,            vec_of(m.kind));
   endtask

   // One clock with the currently driven inputs
   task automatic cyc();
      model_t nxt = model_step(m);
      @(posedge clock);
      #1;
      m = nxt;
      check_model();
   endtask

   task automatic run_to(input int unsigned t);
      for (int i = 0; i < 20 && m.tstate != t; i++) cyc();
      chk("run_to_tstate", 16'(cyc_count), 16'(t));
   endtask

   task automatic finish_instr();
      instr_done = 1'b1;
      cyc();
      instr_done = 1'b0;
   endtask

   task automatic fetch(input logic [7:0] op);
      data_in = op;
      cyc();
   endtask

   initial begin
      m = '{default: 0};
      reset = 1'b1; data_in = 8'h00; rdy = 1'b1; instr_done = 1'b0;
      irq_mask = 1'b1; nnmi = 1'b1; nirq = 1'b1;

      // 1: reset sequence, then a plain fetch
      cyc(); cyc();
      chk("rst_instr", 16'(instr), 16'h0000);
      chk("rst_cyc",   16'(cyc_count), 16'd1);
      chk("rst_kind",  16'(int_kind), 16'd1);
      chk("rst_vec",   vector, 16'hFFFC);
      chk("rst_jam",   16'(jam), 16'd0);
      reset = 1'b0;
      run_to(6);
      finish_instr();
      chk("t1_fetch_pcinc", 16'(pc_inc), 16'd1);
      fetch(8'hA9);
      chk("t1_instr", 16'(instr), 16'h00A9);
      chk("t1_kind",  16'(int_kind), 16'd0);

      // 2: two-cycle instruction back to back
      finish_instr();
      chk("t2_cyc0", 16'(cyc_count), 16'd0);
      chk("t2_hold", 16'(instr), 16'h00A9);
      fetch(8'hEA);
      chk("t2_instr", 16'(instr), 16'h00EA);
      chk("t2_cyc1",  16'(cyc_count), 16'd1);

      // 3: NMI edge at T2 of a 4-cycle instruction
      run_to(2);
      nnmi = 1'b0;
      cyc();
      finish_instr();
      chk("t3_pcinc", 16'(pc_inc), 16'd0);
      fetch(8'h55);
      chk("t3_instr", 16'(instr), 16'h0000);
      chk("t3_kind",  16'(int_kind), 16'd2);
      chk("t3_vec",   vector, 16'hFFFA);
      run_to(6);
      finish_instr();
      chk("t3_no_second_nmi", 16'(pc_inc), 16'd1);
      fetch(8'hEA);
      chk("t3_plain_kind", 16'(int_kind), 16'd0);
      nnmi = 1'b1;

      // 4: masked IRQ, unmasked IRQ, NMI beating IRQ
      nirq = 1'b0;
      finish_instr();
      chk("t4_masked", 16'(pc_inc), 16'd1);
      fetch(8'hA9);
      irq_mask = 1'b0;
      finish_instr();
      fetch(8'h11);
      chk("t4_irq_kind", 16'(int_kind), 16'd3);
      chk("t4_irq_vec",  vector, 16'hFFFE);
      run_to(3);
      nnmi = 1'b0;
      run_to(6);
      finish_instr();
      fetch(8'h22);
      chk("t4_nmi_first", 16'(int_kind), 16'd2);
      run_to(6);
      finish_instr();
      fetch(8'h33);
      chk("t4_irq_after", 16'(int_kind), 16'd3);
      nirq = 1'b1; irq_mask = 1'b1; nnmi = 1'b1;
      run_to(6);
      finish_instr();
      fetch(8'h85);

      // 5: stall at T2 with an NMI edge inside it, then a stalled fetch
      run_to(2);
      rdy = 1'b0;
      cyc();
      nnmi = 1'b0;
      cyc(); cyc();
      chk("t5_stall_cyc", 16'(cyc_count), 16'd2);
      rdy = 1'b1;
      run_to(3);
      finish_instr();
      rdy = 1'b0;
      cyc(); cyc();
      chk("t5_fetch_hold", 16'(opcode_fetch), 16'd1);
      chk("t5_pcinc_hold", 16'(pc_inc), 16'd0);
      rdy = 1'b1;
      fetch(8'h44);
      chk("t5_nmi_kind", 16'(int_kind), 16'd2);
      nnmi = 1'b1;
      run_to(6);
      finish_instr();

      // 6: jam on a never-ending instruction, cleared by reset
      fetch(8'h02);
      for (int i = 0; i < 12; i++) cyc();
      chk("t6_cyc_max", 16'(cyc_count), 16'd7);
      chk("t6_jam",     16'(jam), 16'd1);
      finish_instr();
      chk("t6_jam_frozen", 16'(cyc_count), 16'd7);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("t6_jam_clr", 16'(jam), 16'd0);
      chk("t6_restart", 16'(cyc_count), 16'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         rdy        = ($urandom_range(0, 9) < 8);
         instr_done = ($urandom_range(0, 9) < 4);
         data_in    = 8'($urandom);
         irq_mask   = 1'($urandom);
         nirq       = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) nnmi = ~nnmi;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Cycle sequencer for the 2A03 core; sits directly upstream of the control ROM.
- Tracks the T-state of the current instruction and latches the opcode from the data bus during the fetch cycle.
- Decides when an instruction ends, and polls and prioritises reset/NMI/IRQ by injecting a forced BRK (8'h00) together with an interrupt kind.
- Its instr/cyc_count outputs are the control ROM's opcode and cycle-count inputs.

Parameters:
RESET_OPCODE, 8'h00, opcode injected for reset/NMI/IRQ sequences (BRK).
MAX_CYC, 7, highest legal cyc_count value; reaching it without instr_done means jam.

Ports:
clock  input  1  CPU clock, one T-state per rising edge
reset  input  1  synchronous, active-high reset
data_in  input  8  data bus read value for the current cycle
rdy  input  1  1 = advance; 0 = stall (DMA steal)
instr_done  input  1  from control ROM: current cycle is the last of the instruction
irq_mask  input  1  P.I flag from the datapath
nnmi  input  1  NMI pin, active low, edge-sensitive
nirq  input  1  IRQ pin, active low, level-sensitive
instr  output  8  current opcode
cyc_count  output  3  T-state within the instruction; 0 = fetch cycle
opcode_fetch  output  1  1 when cyc_count==0 (bus reads at PC)
pc_inc  output  1  1 when the fetch cycle should increment PC
int_kind  output  2  00 none, 01 reset, 10 NMI, 11 IRQ; valid for the whole forced BRK
vector  output  16  FFFC (reset), FFFA (NMI), FFFE (IRQ or plain BRK)
jam  output  1  sticky: cyc_count hit MAX_CYC without instr_done

Behaviour:
- Reset (reset==1 at a rising edge) forces the following, whatever the prior state (mid-instruction reset simply restarts):
  - instr = RESET_OPCODE, cyc_count = 1, int_kind = 01, jam = 0
  - nmi_pending = 0, take_int = 0, nmi_prev = 1
  - The reset sequence therefore starts at T1 with no opcode fetch. The control ROM runs the BRK microcode with writes suppressed because int_kind==01.
- opcode_fetch = (cyc_count==0), combinational.
- pc_inc = opcode_fetch & ~take_int, combinational.
- vector decode from int_kind is combinational.
- All state advances only on edges where rdy==1, with one exception: the NMI edge detector runs every cycle regardless of rdy.
- NMI detect: nmi_prev <= nnmi every cycle. When nmi_prev==1 and nnmi==0, nmi_pending <= 1.
- Cycle counting (rdy==1):
  - instr_done==1: cyc_count <= 0. At the same edge, take_int <= nmi_pending | (~nirq & ~irq_mask), and kind_next = NMI if nmi_pending, else IRQ.
  - Otherwise, when cyc_count < MAX_CYC: cyc_count <= cyc_count+1.
  - When cyc_count == MAX_CYC and instr_done==0: hold at MAX_CYC and set jam=1. jam holds until reset; cyc_count then never advances.
- Fetch cycle (cyc_count==0, rdy==1) at the closing edge:
  - take_int==0: instr <= data_in, int_kind <= 00.
  - take_int==1: instr <= RESET_OPCODE, int_kind <= kind_next, take_int <= 0. If the kind is NMI, nmi_pending <= 0 at the same edge.
  - cyc_count <= 1 in both cases.
- A plain BRK fetched from memory gives int_kind=00 and vector FFFE.
- Priority: NMI beats IRQ when both are present at the poll edge. The IRQ is not latched; it is re-polled at the next instr_done.
- NMI edge during a forced IRQ sequence: nmi_pending stays set and is taken at the next poll. Vector hijack is not modelled.
- rdy==0 during a fetch: instr, cyc_count and take_int hold, and opcode_fetch stays 1.
- instr_done is ignored while cyc_count==0. The minimum instruction length is 2 cycles.

Test Plan:
1. Assert reset 2 cycles, release, instr_done on T6 -> instr=00, int_kind=01, vector=FFFC, cyc_count 1..6 then 0; next fetch with data_in=A9 gives instr=A9, pc_inc=1, int_kind=00.
2. Run A9 with instr_done at T1 while feeding data_in=EA on the next fetch -> cyc_count sequence 0,1,0,1; instr goes A9 then EA.
3. Drive nnmi 1->0 at T2 of a 4-cycle instruction; instr_done at T3 -> the next fetch has pc_inc=0, instr=00, int_kind=10, vector=FFFA, and nmi_pending clears. Holding nnmi low causes no second NMI.
4. nirq=0 with irq_mask=1 -> no interrupt taken. Then clear irq_mask and poll -> int_kind=11, vector=FFFE. Also drive nnmi falling and nirq=0 before the same poll -> int_kind=10; IRQ is taken after the NMI sequence's instr_done.
5. rdy=0 for 3 cycles at cyc_count=2 with an nnmi falling edge inside the stall -> cyc_count holds at 2, and the NMI is still taken at the next poll.
6. Fetch data_in=02 and never assert instr_done -> cyc_count reaches 7, jam=1 and holds; reset clears jam and restarts the sequence at T1.
